feature_spi_tx: RTL and testbench

- Serial output end of the feature pipeline. It replaces the parallel top_o_feature_out path.
- Buffers signed 8-bit post-processed features in a small synchronous FIFO.
- Shifts them out MSB-first to an external SPI master, acting as an SPI mode-0 slave on MISO.
- Host-driven SCLK/CS_n are oversampled in the i_clk (clk50m) domain. There is no second clock.

---
 rtl/feature_spi_pkg.sv | 23 ++
 rtl/feature_sync_fifo.sv | 49 ++++
 rtl/feature_spi_tx.sv | 138 +++++++++++++
 tb/tb_feature_spi_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_spi_pkg.sv
// Shared types and constants for the feature SPI transmit path.
package feature_spi_pkg;

  localparam int SPI_BYTE_W  = 8;
  localparam int STATUS_RSVD = 5;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} tx_state_t;

  typedef logic signed [SPI_BYTE_W-1:0] feature_t;

  // Status byte layout: {overflow, underrun, reserved 0, occupancy[4:0]}
  function automatic logic [SPI_BYTE_W-1:0] status_byte(input logic ovf, input logic und,
                                                        input logic [4:0] cnt);
    logic [SPI_BYTE_W-1:0] sb;
    sb              = '0;
    sb[7]           = ovf;
    sb[6]           = und;
    sb[STATUS_RSVD] = 1'b0;
    sb[4:0]         = cnt;
    return sb;
  endfunction

endpackage

// File: rtl/feature_sync_fifo.sv
// Synchronous FIFO on distributed RAM; pointers wrap naturally (DEPTH is a power of 2).
module feature_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/feature_spi_tx.sv
// Feature FIFO drained MSB-first as an SPI mode-0 slave, SCLK/CS_n oversampled on i_clk.
// FEATURE_SPI_TX_STATUS_BYTE_EN prepends a status byte to every frame.
module feature_spi_tx
  import feature_spi_pkg::*;
#(
  parameter int DATA_W      = SPI_BYTE_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_feature_valid,
  input  logic [DATA_W-1:0]           i_feature,
  output logic                        o_ready,
  input  logic                        i_spi_sclk,
  input  logic                        i_spi_cs_n,
  output logic                        o_spi_miso,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_overflow,
  output logic                        o_underrun
);
  localparam int BIT_W = $clog2(DATA_W + 1);

  // Synchronizers are deliberately not reset so a reset mid-frame cannot fake a CS_n fall.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic                   sclk_d, cs_d, sclk_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_ff @(posedge i_clk) begin
    sclk_sync[0] <= i_spi_sclk;
    cs_sync[0]   <= i_spi_cs_n;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sclk_sync[i] <= sclk_sync[i-1];
      cs_sync[i]   <= cs_sync[i-1];
    end
    sclk_d <= sclk_s;
    cs_d   <= cs_s;
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  logic              push, pop, full, empty;
  logic [DATA_W-1:0] rdata;

  assign push    = i_feature_valid && !full;
  assign o_ready = !full;

  feature_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_feature),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (o_fifo_count)
  );

  tx_state_t         state, state_nxt;
  logic              armed, load, status_slot, und_evt, ovf_evt, flag_clr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg, load_val;

`ifdef FEATURE_SPI_TX_STATUS_BYTE_EN
  logic [DATA_W-1:0] status_val;
  assign status_val  = DATA_W'(status_byte(o_overflow, o_underrun, 5'(o_fifo_count)));
  assign status_slot = (state == IDLE);
`else
  assign status_slot = 1'b0;
`endif

  // The byte is loaded on the cycle that enters LOAD, so a byte boundary drives
  // the next MSB on the same detected SCLK fall.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && cs_fall) state_nxt = LOAD;
      LOAD:    state_nxt = cs_rise ? IDLE : SHIFT;
      SHIFT: begin
        if (cs_rise)                                       state_nxt = IDLE;
        else if (sclk_fall && bit_cnt == BIT_W'(DATA_W))   state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
    load     = (state_nxt == LOAD) && (state != LOAD);
    pop      = load && !status_slot && !empty;
    und_evt  = load && !status_slot && empty;
    flag_clr = load && status_slot;
    ovf_evt  = i_feature_valid && full;
    load_val = empty ? '0 : rdata;
`ifdef FEATURE_SPI_TX_STATUS_BYTE_EN
    if (status_slot) load_val = status_val;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      o_spi_miso <= 1'b0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (cs_s) armed <= 1'b1;
      o_overflow <= (o_overflow & ~flag_clr) | ovf_evt;
      o_underrun <= (o_underrun & ~flag_clr) | und_evt;
      if (load) begin
        shreg      <= load_val;
        o_spi_miso <= load_val[DATA_W-1];
        bit_cnt    <= '0;
      end else if (state == IDLE || state_nxt == IDLE) begin
        o_spi_miso <= 1'b0;
        bit_cnt    <= '0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else if (sclk_fall && bit_cnt < BIT_W'(DATA_W)) begin
        shreg      <= shreg << 1;
        o_spi_miso <= shreg[DATA_W-2];
      end
    end
  end

endmodule

// File: tb/tb_feature_spi_tx.sv
// Randomized bench for feature_spi_tx against a queue-based frame model.
module tb_feature_spi_tx;
  localparam int DEPTH = 16;
`ifdef FEATURE_SPI_TX_STATUS_BYTE_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, fv = 1'b0, sclk = 1'b0, cs_n = 1'b1;
  logic [7:0] feat = '0;
  logic       ready, miso, ovf, und;
  logic [4:0] cnt;

  always #5 clk = ~clk;

  feature_spi_tx #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_feature_valid (fv),
    .i_feature       (feat),
    .o_ready         (ready),
    .i_spi_sclk      (sclk),
    .i_spi_cs_n      (cs_n),
    .o_spi_miso      (miso),
    .o_fifo_count    (cnt),
    .o_overflow      (ovf),
    .o_underrun      (und)
  );

  int         total = 0, bad = 0;
  logic [7:0] q[$];
  logic       ovf_m = 1'b0, und_m = 1'b0;
  logic [7:0] rx[$], exp_b[$];
  int         cnt_obs[$], cnt_exp[$];

  // Every frame loads once at CS_n fall and once per completed byte.
  function automatic logic [7:0] model_load(input bit first);
    logic [7:0] v;
    if (STATUS_EN && first) begin
      v = {ovf_m, und_m, 1'b0, 5'(q.size())};
      ovf_m = 1'b0;
      und_m = 1'b0;
    end else if (q.size() > 0) begin
      v = q.pop_front();
    end else begin
      v = 8'h00;
      und_m = 1'b1;
    end
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    und_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_feat(input logic [7:0] v);
    @(negedge clk) begin fv = 1'b1; feat = v; end
    if (q.size() == DEPTH) ovf_m = 1'b1;
    else q.push_back(v);
    @(negedge clk) fv = 1'b0;
  endtask

  task automatic do_frame(input int nbits);
    logic [7:0] sh = '0;
    rx.delete(); exp_b.delete(); cnt_obs.delete(); cnt_exp.delete();
    for (int l = 0; l <= nbits / 8; l++) begin
      exp_b.push_back(model_load(l == 0));
      cnt_exp.push_back(q.size());
    end
    @(negedge clk) cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) cnt_obs.push_back(int'(cnt));
      sh = {sh[6:0], miso};
      if (i % 8 == 7) rx.push_back(sh);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (miso !== 1'b0)  begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    if (cnt !== 5'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    if (ovf !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    if (und !== 1'b0)   begin bad++; $display("FAIL reset_und got=%b exp=0", und); end
  endtask

  task automatic test_stream();
    do_reset();
    push_feat(8'h5A);
    push_feat(8'hC3);
    total++;
    if (int'(cnt) !== q.size()) begin bad++; $display("FAIL stream_precount got=%0d exp=%0d", cnt, q.size()); end
    do_frame(16);
    for (int b = 0; b < rx.size(); b++) begin
      total++;
      if (rx[b] !== exp_b[b]) begin bad++; $display("FAIL stream_byte%0d got=%h exp=%h", b, rx[b], exp_b[b]); end
    end
    for (int b = 0; b < cnt_obs.size(); b++) begin
      total++;
      if (cnt_obs[b] !== cnt_exp[b]) begin bad++; $display("FAIL stream_count%0d got=%0d exp=%0d", b, cnt_obs[b], cnt_exp[b]); end
    end
    total += 2;
    if (ovf !== ovf_m) begin bad++; $display("FAIL stream_ovf got=%b exp=%b", ovf, ovf_m); end
    if (und !== und_m) begin bad++; $display("FAIL stream_und got=%b exp=%b", und, und_m); end
  endtask

  task automatic test_underrun();
    do_reset();
    do_frame(8);
    total += 2;
    if (rx[0] !== exp_b[0]) begin bad++; $display("FAIL underrun_byte got=%h exp=%h", rx[0], exp_b[0]); end
    if (und !== und_m)      begin bad++; $display("FAIL underrun_flag got=%b exp=%b", und, und_m); end
    push_feat(8'h7F);
    do_frame(8);
    total++;
    if (rx[0] !== exp_b[0]) begin bad++; $display("FAIL underrun_next got=%h exp=%h", rx[0], exp_b[0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_feat(8'($urandom));
      total++;
      if (ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL ovf_ready%0d got=%b exp=%b", i, ready, q.size() < DEPTH); end
    end
    total += 2;
    if (int'(cnt) !== q.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", cnt, q.size()); end
    if (ovf !== ovf_m)          begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ovf, ovf_m); end
    do_frame(DEPTH * 8);
    for (int b = 0; b < rx.size(); b++) begin
      total++;
      if (rx[b] !== exp_b[b]) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", b, rx[b], exp_b[b]); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    push_feat(8'hF0);
    do_frame(3);
    push_feat(8'h11);
    do_frame(8);
    total += 2;
    if (rx[0] !== exp_b[0])     begin bad++; $display("FAIL abort_byte got=%h exp=%h", rx[0], exp_b[0]); end
    if (int'(cnt) !== q.size()) begin bad++; $display("FAIL abort_count got=%0d exp=%0d", cnt, q.size()); end
  endtask

  task automatic test_rst_mid();
    int zero_bad = 0;
    do_reset();
    push_feat(8'hAA);
    push_feat(8'h55);
    @(negedge clk) cs_n = 1'b0;
    repeat (4) @(negedge clk);
    repeat (3) begin
      sclk = 1'b1; repeat (4) @(negedge clk);
      sclk = 1'b0; repeat (4) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    q.delete(); ovf_m = 1'b0; und_m = 1'b0;
    total += 2;
    if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
    if (cnt !== 5'd0)  begin bad++; $display("FAIL rstmid_count got=%0d exp=0", cnt); end
    repeat (16) begin
      repeat (4) @(negedge clk);
      if (miso !== 1'b0) zero_bad++;
      sclk = 1'b1; repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    total++;
    if (zero_bad !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d high samples exp=0", zero_bad); end
    @(negedge clk) cs_n = 1'b1;
    repeat (6) @(negedge clk);
    push_feat(8'h3C);
    do_frame(8);
    total++;
    if (rx[0] !== exp_b[0]) begin bad++; $display("FAIL rstmid_rearm got=%h exp=%h", rx[0], exp_b[0]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) push_feat(8'($urandom));
      do_frame($urandom_range(1, 4) * 8 + $urandom_range(0, 3));
      for (int b = 0; b < rx.size(); b++) begin
        total++;
        if (rx[b] !== exp_b[b]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, b, rx[b], exp_b[b]); end
      end
      for (int b = 0; b < cnt_obs.size(); b++) begin
        total++;
        if (cnt_obs[b] !== cnt_exp[b]) begin bad++; $display("FAIL rand%0d_count%0d got=%0d exp=%0d", it, b, cnt_obs[b], cnt_exp[b]); end
      end
      total += 2;
      if (ovf !== ovf_m) begin bad++; $display("FAIL rand%0d_ovf got=%b exp=%b", it, ovf, ovf_m); end
      if (und !== und_m) begin bad++; $display("FAIL rand%0d_und got=%b exp=%b", it, und, und_m); end
    end
  endtask

`ifdef FEATURE_SPI_TX_STATUS_BYTE_EN
  task automatic test_status();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_feat(8'($urandom));
    // Re-raise overflow after the status byte cleared it, while the FIFO is still full.
    fork
      do_frame(13 * 8);
      begin
        repeat (20) @(negedge clk);
        fv = 1'b1; feat = 8'hEE;
        @(negedge clk) fv = 1'b0;
        ovf_m = 1'b1;
      end
    join
    total++;
    if (rx[0] !== exp_b[0]) begin bad++; $display("FAIL status_first got=%h exp=%h", rx[0], exp_b[0]); end
    do_frame(3 * 8 + 4);
    total++;
    if (rx[0] !== 8'h83) begin bad++; $display("FAIL status_byte got=%h exp=83", rx[0]); end
    for (int b = 1; b < rx.size(); b++) begin
      total++;
      if (rx[b] !== exp_b[b]) begin bad++; $display("FAIL status_feat%0d got=%h exp=%h", b, rx[b], exp_b[b]); end
    end
    total += 2;
    if (ovf !== ovf_m) begin bad++; $display("FAIL status_ovf got=%b exp=%b", ovf, ovf_m); end
    if (und !== und_m) begin bad++; $display("FAIL status_und got=%b exp=%b", und, und_m); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_overflow();
    test_abort();
    test_rst_mid();
    test_random();
`ifdef FEATURE_SPI_TX_STATUS_BYTE_EN
    test_status();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
